// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its word assembler.
// The CSUM state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/word_assembler.sv
// Collects little-endian bytes into a 32-bit word; word_valid flags the byte
// that completes a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CntW = $clog2(BYTES_PER_WORD);

  logic [CntW-1:0] byte_cnt;

  assign word_valid = byte_en && (byte_cnt == CntW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_en) begin
      word[{byte_cnt, 3'b000} +: 8] <= byte_data;
      byte_cnt                      <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a counted byte image into program memory, then releases
// the CPU reset. Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  program_loader_if.slave     bus,
  output logic                cpu_reset_n,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam logic [8*HDR_BYTES-1:0] DepthN = (8*HDR_BYTES)'(MEMORY_DEPTH);

  state_t                 state, state_nx;
  logic                   transfer;
  logic                   start_ok;
  logic [7:0]             hdr_lo;
  logic [8*HDR_BYTES-1:0] hdr_n;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [ADDR_WIDTH-1:0]  last_idx;
  logic                   word_valid;
  logic [31:0]            word;

  assign transfer = bus.byte_valid && bus.byte_ready;
  assign start_ok = load_start &&
                    (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign hdr_n    = {bus.byte_data, hdr_lo};

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (transfer && state == ST_DATA),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over header and data bytes; the checksum byte itself is excluded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (transfer && state != ST_CSUM) begin
      csum <= csum ^ bus.byte_data;
    end
  end
`endif

  always_comb begin
    state_nx       = state;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = word_idx;
    bus.mem_wdata  = word;
    busy           = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (load_start) state_nx = ST_HDR_LO;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (load_start) state_nx = ST_HDR_LO;
      end
      ST_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (load_start) state_nx = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        bus.byte_ready = 1'b1;
        if (transfer) state_nx = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        bus.byte_ready = 1'b1;
        if (transfer) begin
          if (hdr_n > DepthN)   state_nx = ST_ERROR;
          else if (hdr_n == '0) state_nx = ST_DONE;
          else                  state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        bus.byte_ready = 1'b1;
        if (word_valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        bus.mem_we = 1'b1;
        if (word_idx != last_idx) state_nx = ST_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        else                      state_nx = ST_CSUM;
`else
        else                      state_nx = ST_DONE;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        bus.byte_ready = 1'b1;
        if (transfer) state_nx = (bus.byte_data == csum) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      hdr_lo       <= '0;
      word_idx     <= '0;
      last_idx     <= '0;
      words_loaded <= '0;
      cpu_reset_n  <= 1'b0;
    end else begin
      state <= state_nx;
      // Release only after a full cycle in DONE; a new load re-asserts at once.
      cpu_reset_n <= (state == ST_DONE) && (state_nx == ST_DONE);
      if (start_ok) begin
        word_idx     <= '0;
        words_loaded <= '0;
      end
      if (state == ST_HDR_LO && transfer) hdr_lo <= bus.byte_data;
      if (state == ST_HDR_HI && transfer) last_idx <= hdr_n[ADDR_WIDTH-1:0] - 1'b1;
      if (state == ST_WRITE) begin
        words_loaded <= words_loaded + 1'b1;
        if (state_nx == ST_DATA) word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule
